johnson_phase_decoder: RTL
==========================

// Module: johnson_phase_decoder
// PURPOSE
//  Downstream consumer of the 5-stage twisted-ring (Johnson) counter with parallel OR-load.
//  Samples the ring state {a,b,c,d,e} and checks that it is one of the 2N legal Johnson codes.
//  Converts each legal code to a binary phase index and a one-hot phase strobe.
//  Tracks lock and sequence errors, and counts completed ring revolutions for the sequencer.
// PARAMETERS
//  N        5  ring stages; legal codes = 2N; phase range 0..2N-1
//  PW       4  phase index width, >= clog2(2N)
//  REV_W    8  revolution counter width; wraps modulo 2^REV_W
//  LOCK_CNT 2  consecutive correct steps needed to go from SYNC to LOCKED
// PORTS
//  clk       in   1      rising-edge clock, shared with the ring counter
//  clear     in   1      asynchronous reset, active-low (0 = reset)
//  ring_in   in   N      ring state, MSB = stage a, LSB = stage e
//  valid_in  in   1      ring_in is valid this cycle; the ring advanced one step
//  resync    in   1      synchronous pulse: return to SYNC and clear err
//  phase     out  PW     decoded phase index of the last accepted sample
//  onehot    out  2N     one-hot phase strobe; nonzero only while locked
//  locked    out  1      FSM is in LOCKED
//  err       out  1      sticky error flag
//  rev_cnt   out  REV_W  completed revolutions while locked
//  rev_wrap  out  1      1-cycle pulse on a 2N-1 -> 0 transition while locked
// BEHAVIOUR
//  Reset (clear=0, async): state=SYNC; phase=0; onehot=0; locked=0; err=0; rev_cnt=0; rev_wrap=0; step counter=0.
//  Legal code: ones contiguous from the MSB (incl. all-zero), or ones contiguous to the LSB.
//   - MSB=1 or all-zero: phase = popcount.
//   - Otherwise: phase = 2N - popcount.
//   - Example, N=5: 00000->0, 10000->1, 11111->5, 01111->6, 00001->9.
//  All outputs are registered. Latency: sample at edge k appears on the outputs after edge k+1.
//  valid_in=0: all state holds; onehot=0; rev_wrap=0.
//  Expected next phase = (phase+1) mod 2N. Wrap is 2N-1 -> 0.
//  FSM states: SYNC, LOCKING, LOCKED, ERROR.
//   SYNC: legal sample -> LOCKING; phase loads; step counter=0. Illegal sample -> stay in SYNC, no err.
//   LOCKING, sample matches expected: counter++; at LOCK_CNT -> LOCKED.
//   LOCKING, legal sample but mismatch: counter=0, phase reloads, stay in LOCKING.
//   LOCKING, illegal sample: -> SYNC.
//   LOCKED, sample matches expected: phase updates; onehot[phase]=1 for one cycle.
//   LOCKED, on a 2N-1 -> 0 step: rev_cnt++ (wraps modulo 2^REV_W); rev_wrap=1.
//   LOCKED, illegal sample or wrong step: -> ERROR; err=1; onehot=0; phase holds the last good value.
//   ERROR: holds until resync; ignores valid_in.
//  resync=1 has priority over valid_in in any state. Next state is SYNC; err=0.
//   rev_cnt is preserved across resync; only clear resets it.
//  clear asserted mid-operation: immediate reset values, independent of clk.
//   On release, SYNC resumes at the next clk edge.
// CONFIGURATION
//  Macro JDEC_ALLOW_HOLD_EN.
//  Defined: in LOCKED/LOCKING, a sample equal to the current phase is a legal hold.
//   - No error; state, phase and step counter unchanged.
//   - onehot=0 that cycle; rev_cnt unchanged.
//  Undefined: a repeated phase is a wrong step.
//   - From LOCKED -> ERROR. From LOCKING -> counter reset.
// STRUCTURE
//  Shared package jdec_pkg holds:
//   - state encoding: SYNC=2'd0, LOCKING=2'd1, LOCKED=2'd2, ERROR=2'd3
//   - default N/PW constants
//   - function next_phase(p, n) = (p+1) mod 2n
//  Sub-module johnson_code_check (purely combinational): ring_in -> {legal, phase}.
//  Top level holds the FSM, step counter, output registers and revolution counter.
// TESTING
//  1. clear=0, then release; feed ring 00000,10000,11000,11100 with valid_in=1.
//     -> locked=1 after the 3rd accepted step; onehot=0000001000 (phase 3) one cycle after 11100.
//  2. Locked, feed 00011,00001,00000.
//     -> phase 8,9,0; rev_wrap=1 exactly with phase 0; rev_cnt 0->1.
//  3. Locked, inject 10100 (illegal).
//     -> next cycle err=1, locked=0, onehot=0, phase holds; remains so until resync.
//  4. Locked at phase 4 (11110), feed 11110 again.
//     -> JDEC_ALLOW_HOLD_EN defined: no error, onehot=0, phase=4.
//     -> Undefined: err=1.
//  5. In ERROR pulse resync with valid_in=1 and ring 11111.
//     -> err=0, state SYNC; 11111 not loaded that cycle; relock from the next samples.
//  6. Assert clear mid-revolution between edges.
//     -> all outputs go to reset values immediately; rev_cnt=0.

Source files
------------

// File: rtl/jdec_pkg.sv
// rtl/jdec_pkg.sv - shared state encoding, default sizes and phase helper for the Johnson phase decoder
package jdec_pkg;

  localparam int N_DEF  = 5;
  localparam int PW_DEF = 4;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2,
    ERROR   = 2'd3
  } state_t;

  // Successor of phase p on a ring of n stages (2n legal codes)
  function automatic int next_phase(input int p, input int n);
    return (p + 1) % (2 * n);
  endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// rtl/johnson_phase_decoder_if.sv - ring sample bus from the twisted-ring counter to the decoder
interface johnson_phase_decoder_if #(
  parameter int N = jdec_pkg::N_DEF
);
  logic [N-1:0] ring_in;
  logic         valid_in;
  logic         resync;

  modport master (output ring_in, output valid_in, output resync);
  modport slave  (input  ring_in, input  valid_in, input  resync);
endinterface

// File: rtl/johnson_code_check.sv
// rtl/johnson_code_check.sv - combinational legality check and phase decode of one Johnson code
module johnson_code_check
  import jdec_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int PW = PW_DEF
) (
  input  logic [N-1:0]  ring_in,
  output logic          legal,
  output logic [PW-1:0] phase
);

  int           ones;
  logic [N-1:0] top_mask;
  logic [N-1:0] low_mask;

  // Legal codes are a run of ones anchored at the MSB or at the LSB; the count of ones gives the phase
  always_comb begin
    ones     = 0;
    top_mask = '0;
    low_mask = '0;
    for (int i = 0; i < N; i++) begin
      ones += int'(ring_in[i]);
    end
    for (int i = 0; i < N; i++) begin
      top_mask[i] = (i >= N - ones);
      low_mask[i] = (i < ones);
    end
    legal = (ring_in == top_mask) || (ring_in == low_mask);
    if (ring_in[N-1] || (ring_in == '0)) begin
      phase = PW'(ones);
    end else begin
      phase = PW'(2 * N - ones);
    end
  end

endmodule

// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - Johnson ring phase decoder with lock FSM and revolution counter; option JDEC_ALLOW_HOLD_EN
module johnson_phase_decoder
  import jdec_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int PW       = PW_DEF,
  parameter int REV_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic                clk,
  input  logic                clear,
  johnson_phase_decoder_if.slave ring,
  output logic [PW-1:0]       phase,
  output logic [2*N-1:0]      onehot,
  output logic                locked,
  output logic                err,
  output logic [REV_W-1:0]    rev_cnt,
  output logic                rev_wrap
);

  localparam int SW = $clog2(LOCK_CNT + 1);
  localparam logic [2*N-1:0] ONE_LSB = {{(2*N-1){1'b0}}, 1'b1};

  state_t        state;
  logic [SW-1:0] step_cnt;
  logic [SW-1:0] step_nxt;
  logic          code_legal;
  logic [PW-1:0] code_phase;
  logic [PW-1:0] exp_phase;
  logic          match;
  logic          is_hold;
  logic          is_wrap;

  johnson_code_check #(.N(N), .PW(PW)) u_check (
    .ring_in (ring.ring_in),
    .legal   (code_legal),
    .phase   (code_phase)
  );

  assign exp_phase = PW'(next_phase(int'(phase), N));
  assign match     = code_legal && (code_phase == exp_phase);
  assign is_wrap   = (phase == PW'(2 * N - 1));
  assign step_nxt  = step_cnt + 1'b1;
  assign locked    = (state == LOCKED);

`ifdef JDEC_ALLOW_HOLD_EN
  // A stalled ring repeating the current code is tolerated as a hold
  assign is_hold = code_legal && (code_phase == phase);
`else
  assign is_hold = 1'b0;
`endif

  // Lock FSM, step counter, phase/strobe outputs and revolution counter
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state    <= SYNC;
      step_cnt <= '0;
      phase    <= '0;
      onehot   <= '0;
      err      <= 1'b0;
      rev_cnt  <= '0;
      rev_wrap <= 1'b0;
    end else begin
      onehot   <= '0;
      rev_wrap <= 1'b0;
      if (ring.resync) begin
        state    <= SYNC;
        err      <= 1'b0;
        step_cnt <= '0;
      end else if (ring.valid_in) begin
        case (state)
          SYNC: begin
            if (code_legal) begin
              state    <= LOCKING;
              phase    <= code_phase;
              step_cnt <= '0;
            end
          end
          LOCKING: begin
            if (!code_legal) begin
              state    <= SYNC;
              step_cnt <= '0;
            end else if (!is_hold) begin
              phase <= code_phase;
              if (match) begin
                step_cnt <= step_nxt;
                if (step_nxt == SW'(LOCK_CNT)) begin
                  state <= LOCKED;
                end
              end else begin
                step_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (!is_hold) begin
              if (match) begin
                phase  <= code_phase;
                onehot <= ONE_LSB << code_phase;
                if (is_wrap) begin
                  rev_cnt  <= rev_cnt + 1'b1;
                  rev_wrap <= 1'b1;
                end
              end else begin
                state <= ERROR;
                err   <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
